sel_mux_reg: RTL and testbench

SEL_MUX_REG -- requirements
Module: sel_mux_reg

---
 rtl/sel_mux_reg.sv | 108 ++++++++++
 tb/tb_sel_mux_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sel_mux_reg.sv
// sel_mux_reg: N-channel valid/ready selector feeding a single registered
// output entry. Channel choice is either the fixed `sel` input or, when the
// SEL_MUX_RR_EN macro is defined, an optional round-robin search selected by
// rr_mode. Without SEL_MUX_RR_EN the block is fixed-select only and carries
// no round-robin state.
module sel_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
`ifdef SEL_MUX_RR_EN
  input  logic                      rr_mode,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic              accept_en;
  logic              grant;
  logic [SELW-1:0]   chosen;
  logic [WIDTH-1:0]  sel_data;
  logic              in_xfer;

`ifdef SEL_MUX_RR_EN
  logic [SELW-1:0]   rr_ptr;
  logic [SELW-1:0]   next_ptr;
  int                rr_idx;
`endif

  // The output entry can take a new word when it is empty or being drained.
  assign accept_en = !out_valid || out_ready;

  // Pick the channel: fixed select by default, round-robin search when enabled.
  always_comb begin
    chosen = sel;
    grant  = (int'(sel) < CHANNELS);
`ifdef SEL_MUX_RR_EN
    rr_idx = 0;
    if (rr_mode) begin
      chosen = '0;
      grant  = 1'b0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        rr_idx = int'(rr_ptr) + k;
        if (rr_idx >= CHANNELS) rr_idx = rr_idx - CHANNELS;
        if (in_valid[rr_idx]) begin
          chosen = rr_idx[SELW-1:0];
          grant  = 1'b1;
        end
      end
    end
`endif
  end

  // Drive ready only to the chosen channel and steer its data to the register.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant && (int'(chosen) == i)) begin
        in_ready[i] = accept_en && rst_n;
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_xfer = |(in_ready & in_valid);

  // Single output entry: load on input transfer, clear when drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (accept_en) begin
      out_valid <= in_xfer;
      if (in_xfer) begin
        out_data <= sel_data;
        out_chan <= chosen;
      end
    end
  end

`ifdef SEL_MUX_RR_EN
  // Pointer moves one past the granted channel, wrapping at the last channel.
  always_comb begin
    next_ptr = chosen + SELW'(1);
    if (int'(chosen) == CHANNELS - 1) next_ptr = '0;
  end

  // Round-robin pointer advances only when a word is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (in_xfer) begin
      rr_ptr <= next_ptr;
    end
  end
`endif

endmodule

// File: tb/tb_sel_mux_reg.sv
// tb_sel_mux_reg: directed self-checking bench for sel_mux_reg. A 4-channel
// instance covers the main behaviour; a 5-channel instance covers the
// out-of-range select boundary. Round-robin scenarios compile only when
// SEL_MUX_RR_EN is defined.
module tb_sel_mux_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        rr_mode;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [2:0]  sel5;
  logic [7:0]  out_data5;
  logic [2:0]  out_chan5;
  logic        out_valid5;

  int n_cmp;
  int n_fail;

  sel_mux_reg #(.WIDTH(8), .CHANNELS(4), .SELW(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel),
`ifdef SEL_MUX_RR_EN
    .rr_mode(rr_mode),
`endif
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  sel_mux_reg #(.WIDTH(8), .CHANNELS(5), .SELW(3)) u5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .sel(sel5),
`ifdef SEL_MUX_RR_EN
    .rr_mode(1'b0),
`endif
    .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
    .out_ready(out_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset asserted at time 0 must clear outputs and ready before any clock edge.
  task automatic test_reset();
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_out_data got %h want 00", out_data); end
    n_cmp++; if (out_chan !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_out_chan got %0d want 0", out_chan); end
    n_cmp++; if (out_valid5 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid5 got %b want 0", out_valid5); end
    in_valid = 4'hF;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 0000", in_ready); end
    in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single word through fixed select on channel 2, then the register drains.
  task automatic test_basic();
    sel       = 2'd2;
    in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL basic_in_ready got %b want 0100", in_ready); end
    @(negedge clk);
    in_valid = 4'b0000;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_out_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL basic_out_data got %h want a5", out_data); end
    n_cmp++; if (out_chan !== 2'd2) begin n_fail++; $display("[TB] FAIL basic_out_chan got %0d want 2", out_chan); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_drain got %b want 0", out_valid); end
  endtask

  // Full register stalled while sel toggles; held word stays, no new word lost.
  task automatic test_stall();
    sel       = 2'd0;
    in_data   = {24'h0, 8'h11};
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_fail++; $display("[TB] FAIL stall_load got v=%b d=%h want v=1 d=11", out_valid, out_data); end
    in_data = {24'h0, 8'h22};
    for (int c = 0; c < 4; c++) begin
      sel = 2'(c);
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL stall_in_ready[%0d] got %b want 0000", c, in_ready); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_chan !== 2'd0) begin n_fail++; $display("[TB] FAIL stall_hold[%0d] got v=%b d=%h c=%0d want v=1 d=11 c=0", c, out_valid, out_data, out_chan); end
    end
    sel       = 2'd0;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL stall_release_ready got %b want 0001", in_ready); end
    @(negedge clk);
    in_valid = 4'b0000;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_chan !== 2'd0) begin n_fail++; $display("[TB] FAIL stall_new_word got v=%b d=%h c=%0d want v=1 d=22 c=0", out_valid, out_data, out_chan); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_drain got %b want 0", out_valid); end
  endtask

  // Eight back-to-back words on channel 1, one per cycle with no bubbles.
  task automatic test_back_to_back();
    sel       = 2'd1;
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      in_data = {16'h0, 8'(k), 8'h0};
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(k) || out_chan !== 2'd1) begin n_fail++; $display("[TB] FAIL stream[%0d] got v=%b d=%h c=%0d want v=1 d=%h c=1", k, out_valid, out_data, out_chan, 8'(k)); end
    end
    in_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_drain got %b want 0", out_valid); end
  endtask

  // Five channels: select 5 is out of range, select 4 is the last legal one.
  task automatic test_bad_sel();
    out_ready = 1'b1;
    in_data5  = {8'h44, 8'h33, 8'h22, 8'h11, 8'h10};
    in_valid5 = 5'h1F;
    sel5      = 3'd5;
    #1;
    n_cmp++; if (in_ready5 !== 5'b00000) begin n_fail++; $display("[TB] FAIL badsel_in_ready got %b want 00000", in_ready5); end
    @(negedge clk);
    n_cmp++; if (out_valid5 !== 1'b0) begin n_fail++; $display("[TB] FAIL badsel_out_valid got %b want 0", out_valid5); end
    sel5 = 3'd4;
    #1;
    n_cmp++; if (in_ready5 !== 5'b10000) begin n_fail++; $display("[TB] FAIL lastsel_in_ready got %b want 10000", in_ready5); end
    @(negedge clk);
    in_valid5 = 5'h00;
    n_cmp++; if (out_valid5 !== 1'b1 || out_data5 !== 8'h44 || out_chan5 !== 3'd4) begin n_fail++; $display("[TB] FAIL lastsel_out got v=%b d=%h c=%0d want v=1 d=44 c=4", out_valid5, out_data5, out_chan5); end
    @(negedge clk);
    n_cmp++; if (out_valid5 !== 1'b0) begin n_fail++; $display("[TB] FAIL lastsel_drain got %b want 0", out_valid5); end
    sel5 = 3'd0;
  endtask

  // Asynchronous reset mid-cycle while stalled discards the held word.
  task automatic test_reset_stall();
    out_ready = 1'b0;
    sel       = 2'd3;
    in_data   = {8'h5A, 24'h0};
    in_valid  = 4'b1000;
    @(negedge clk);
    in_valid = 4'b0000;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_chan !== 2'd3) begin n_fail++; $display("[TB] FAIL rststall_load got v=%b d=%h c=%0d want v=1 d=5a c=3", out_valid, out_data, out_chan); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin n_fail++; $display("[TB] FAIL rststall_async got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid, out_data, out_chan); end
    in_valid = 4'b1000;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rststall_in_ready got %b want 0000", in_ready); end
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rststall_after got v=%b d=%h want v=0 d=00", out_valid, out_data); end
  endtask

`ifdef SEL_MUX_RR_EN
  // Round-robin from pointer 0 with all channels valid, then a sparse pattern.
  task automatic test_round_robin();
    int exp_a [5] = '{0, 1, 2, 3, 0};
    int exp_b [3] = '{3, 1, 3};
    rr_mode   = 1'b1;
    out_ready = 1'b1;
    in_data   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    in_valid  = 4'hF;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL rr_first_ready got %b want 0001", in_ready); end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_chan !== 2'(exp_a[j]) || out_data !== 8'(8'hD0 + exp_a[j])) begin n_fail++; $display("[TB] FAIL rr_all[%0d] got v=%b c=%0d d=%h want c=%0d", j, out_valid, out_chan, out_data, exp_a[j]); end
    end
    in_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (out_chan !== 2'd1) begin n_fail++; $display("[TB] FAIL rr_ptr_step got %0d want 1", out_chan); end
    in_valid = 4'b1010;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_chan !== 2'(exp_b[j])) begin n_fail++; $display("[TB] FAIL rr_sparse[%0d] got v=%b c=%0d want c=%0d", j, out_valid, out_chan, exp_b[j]); end
    end
    in_valid = 4'b0000;
    rr_mode  = 1'b0;
    @(negedge clk);
  endtask
`endif

  // Sequence all scenarios and report.
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    sel       = '0;
    rr_mode   = 1'b0;
    out_ready = 1'b1;
    in_data5  = '0;
    in_valid5 = '0;
    sel5      = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_bad_sel();
    test_reset_stall();
`ifdef SEL_MUX_RR_EN
    test_round_robin();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
